writeback_demux: RTL and testbench

WRITEBACK_DEMUX -- requirements
Module: writeback_demux

---
 rtl/writeback_demux_pkg.sv | 18 +
 rtl/writeback_demux.sv | 75 +++++++
 tb/tb_writeback_demux.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/writeback_demux_pkg.sv
// Shared definitions for the write-back demultiplexer: datapath width,
// destination select encodings and FSM state encoding.
package writeback_demux_pkg;

    localparam int WB_W = 8;

    // Destination selects; same encoding as the operand-mux selects.
    localparam logic [1:0] DEST_REGA = 2'b00;
    localparam logic [1:0] DEST_REGB = 2'b01;
    localparam logic [1:0] DEST_MEM  = 2'b10;
    localparam logic [1:0] DEST_NONE = 2'b11;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/writeback_demux.sv
// Write-back demultiplexer: routes one result per cycle to regA, regB,
// a single-entry data-memory write port, or discards it. A memory write
// that is not yet taken stalls all further write-backs to keep order.
module writeback_demux
    import writeback_demux_pkg::*;
#(
    parameter int W = WB_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_dest,
    input  logic [W-1:0] in_addr,
    output logic [W-1:0] reg_a,
    output logic [W-1:0] reg_b,
    output logic         mem_wvalid,
    input  logic         mem_wready,
    output logic [W-1:0] mem_waddr,
    output logic [W-1:0] mem_wdata,
    output logic         busy
);

    wb_state_t state, state_nxt;
    logic      accept;
    logic      acc_mem;

    // The pending slot frees up in the same cycle memory takes it, so a
    // new request can be accepted then (no bubble between writes).
    assign mem_wvalid = (state == MEM_WAIT);
    assign busy       = mem_wvalid;
    assign in_ready   = !mem_wvalid || mem_wready;
    assign accept     = in_valid && in_ready;
    assign acc_mem    = accept && (in_dest == DEST_MEM);

    // State register; reset drops any pending memory write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: enter MEM_WAIT on a memory accept, leave once the write
    // is taken unless a new memory write reloads the slot that same cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (acc_mem) state_nxt = MEM_WAIT;
            MEM_WAIT: if (mem_wready && !acc_mem) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Datapath: load the selected destination on accept; discard leaves
    // everything untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a     <= '0;
            reg_b     <= '0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else if (accept) begin
            case (in_dest)
                DEST_REGA: reg_a <= in_data;
                DEST_REGB: reg_b <= in_data;
                DEST_MEM: begin
                    mem_waddr <= in_addr;
                    mem_wdata <= in_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_demux.sv
// Directed bench for writeback_demux. Memory writes are checked by a
// scoreboard: stimulus pushes the expected (addr,data) on issue and a
// monitor pops and compares on every memory handshake.
module tb_writeback_demux;
    import writeback_demux_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_dest;
    logic [W-1:0] in_addr;
    logic [W-1:0] reg_a;
    logic [W-1:0] reg_b;
    logic         mem_wvalid;
    logic         mem_wready;
    logic [W-1:0] mem_waddr;
    logic [W-1:0] mem_wdata;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*W-1:0] exp_q[$];

    writeback_demux #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest), .in_addr(in_addr),
        .reg_a(reg_a), .reg_b(reg_b),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake happens at the coming rising edge.
    always @(negedge clk) begin
        if (rst_n && mem_wvalid && mem_wready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_mem_write", {mem_waddr, mem_wdata}, 32'hDEAD);
            end else begin
                logic [2*W-1:0] e;
                e = exp_q.pop_front();
                chk("mem_write_addr_data", {mem_waddr, mem_wdata}, e);
            end
        end
        if (rst_n) chk("busy_eq_wvalid", busy, mem_wvalid);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] dest, input logic [W-1:0] data, input logic [W-1:0] addr);
        in_valid = 1'b1;
        in_dest  = dest;
        in_data  = data;
        in_addr  = addr;
        if (dest == DEST_MEM) exp_q.push_back({addr, data});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = DEST_NONE;
        in_addr = '0; mem_wready = 1'b0;
        #1;
        chk("rst_reg_a", reg_a, 0);
        chk("rst_reg_b", reg_b, 0);
        chk("rst_wvalid", mem_wvalid, 0);
        chk("rst_waddr", mem_waddr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_in_ready", in_ready, 1);
        tick(); tick();
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", in_ready, 1);

        // Register write to regA
        drive(DEST_REGA, 8'h5A, 8'h00);
        tick();
        in_valid = 1'b0;
        chk("t1_reg_a", reg_a, 8'h5A);
        chk("t1_reg_b", reg_b, 0);
        chk("t1_wvalid", mem_wvalid, 0);

        // Memory write stalled 3 cycles; a regA write waits behind it
        drive(DEST_MEM, 8'hC3, 8'h10);
        tick();
        drive(DEST_REGA, 8'hEE, 8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_wvalid", mem_wvalid, 1);
            chk("t2_stall_in_ready", in_ready, 0);
            chk("t2_stall_waddr", mem_waddr, 8'h10);
            chk("t2_stall_wdata", mem_wdata, 8'hC3);
            chk("t2_stall_reg_a", reg_a, 8'h5A);
            tick();
        end
        mem_wready = 1'b1;
        #1;
        chk("t2_release_wvalid", mem_wvalid, 1);
        chk("t2_release_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t2_reg_a_same_edge", reg_a, 8'hEE);
        chk("t2_done_wvalid", mem_wvalid, 0);

        // Back-to-back memory writes, no bubble
        for (int i = 1; i <= 3; i++) begin
            logic [W-1:0] d;
            d = W'(i);
            drive(DEST_MEM, d, 8'h1F + d);
            tick();
            chk("t3_b2b_wvalid", mem_wvalid, 1);
            chk("t3_b2b_wdata", mem_wdata, d);
        end
        in_valid = 1'b0;
        tick();
        chk("t3_end_wvalid", mem_wvalid, 0);

        // Discard leaves all state alone
        drive(DEST_NONE, 8'hFF, 8'hAB);
        tick();
        in_valid = 1'b0;
        chk("t4_reg_a", reg_a, 8'hEE);
        chk("t4_reg_b", reg_b, 0);
        chk("t4_wvalid", mem_wvalid, 0);
        chk("t4_waddr", mem_waddr, 8'h22);
        chk("t4_wdata", mem_wdata, 8'h03);

        // regB write completes on the same edge as a pending memory write
        mem_wready = 1'b0;
        drive(DEST_MEM, 8'h44, 8'h30);
        tick();
        mem_wready = 1'b1;
        drive(DEST_REGB, 8'h77, 8'h00);
        #1 chk("t5_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t5_reg_b", reg_b, 8'h77);
        chk("t5_wvalid_idle", mem_wvalid, 0);
        chk("t5_reg_a", reg_a, 8'hEE);

        // Asynchronous reset while a write is pending
        mem_wready = 1'b0;
        drive(DEST_MEM, 8'h99, 8'h40);
        tick();
        in_valid = 1'b0;
        chk("t6_pending", mem_wvalid, 1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_async_wvalid", mem_wvalid, 0);
        chk("t6_async_in_ready", in_ready, 1);
        chk("t6_async_reg_b", reg_b, 0);
        tick();
        rst_n = 1'b1;
        mem_wready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_reissue", mem_wvalid, 0);
        end

        tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: timeout at %0t", $time);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
